mem_block_mover: RTL and testbench
==================================

MEM_BLOCK_MOVER -- requirements
Module: mem_block_mover

Interface
REQ-001 Parameter ADDR_W, 13, word-address width of the memory slave port.
REQ-002 Parameter DATA_W, 32, data width; byteenable width is DATA_W/8.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 start  in  1  one-cycle command strobe; ignored while busy=1.
REQ-006 mode  in  1  0=copy (read src, write dst), 1=fill (write fill_value to dst).
REQ-007 src_addr  in  ADDR_W  first source word address, copy mode only.
REQ-008 dst_addr  in  ADDR_W  first destination word address.
REQ-009 length  in  ADDR_W+1  word count, 0..2^ADDR_W.
REQ-010 fill_value  in  DATA_W  fill-mode data word.
REQ-011 abort  in  1  stop the transfer at the next word boundary.
REQ-012 busy  out  1  high from the cycle after accepted start until done.
REQ-013 done  out  1  one-cycle pulse at completion or abort.
REQ-014 aborted  out  1  held high with done when the transfer ended by abort; cleared on next start.
REQ-015 checksum  out  DATA_W  modulo-2^DATA_W sum of all words written by the last transfer.
REQ-016 address  out  ADDR_W  memory word address.
REQ-017 byteenable  out  DATA_W/8  always all-ones during access.
REQ-018 chipselect  out  1  memory access strobe.
REQ-019 write  out  1  write qualifier; read when chipselect=1, write=0.
REQ-020 writedata  out  DATA_W  write data.
REQ-021 clken  out  1  memory clock enable; constant 1.
REQ-022 readdata  in  DATA_W  memory read data, valid exactly one cycle after read issue; no waitrequest.

Function
REQ-023 Start accepted on rising clk with start=1, busy=0; src/dst/length/mode/fill_value latched into internal registers.
REQ-024 FSM states: IDLE, RD, WR, FIN.
REQ-025 IDLE->RD on accepted start, mode=0, length>0; IDLE->WR on mode=1, length>0; IDLE->FIN on length=0.
REQ-026 RD: chipselect=1, write=0, address=src pointer; next state WR.
REQ-027 WR: chipselect=1, write=1, address=dst pointer; writedata=readdata (copy) or fill_value (fill).
REQ-028 WR exit: decrement remaining count, increment both pointers; if remaining becomes 0 or abort=1 -> FIN, else RD (copy) or WR (fill).
REQ-029 Copy throughput: 2 cycles/word; fill throughput: 1 cycle/word.
REQ-030 Pointers increment modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0).
REQ-031 checksum cleared on accepted start; adds writedata in every WR cycle.
REQ-032 abort in RD: the pending WR still completes (the word is written), then FIN; abort in IDLE/FIN ignored.
REQ-033 FIN: done=1 for exactly one cycle, busy=0 from the same cycle; next state IDLE.
REQ-034 start in FIN or IDLE on the same cycle as done is ignored while busy=1 only; start during FIN is accepted the following cycle only if reasserted.
REQ-035 chipselect=0, write=0 in IDLE and FIN; address/writedata hold last value.

Reset
REQ-036 reset_n=0 forces IDLE, busy=0, done=0, aborted=0, checksum=0, chipselect=0, write=0, address=0, writedata=0; clken stays 1.
REQ-037 Reset mid-transfer abandons the transfer immediately with no further memory accesses and no done pulse.

Verification
REQ-038 Copy src=0x010, dst=0x100, length=4, memory 0x010..0x013=1,2,3,4 -> 0x100..0x103=1,2,3,4; done 9 cycles after start; checksum=10.
REQ-039 Fill dst=0x1FFE, length=4, fill_value=0xA5A5A5A5 -> writes at 0x1FFE, 0x1FFF, 0x000, 0x001; checksum=0x96969694.
REQ-040 length=0 -> no chipselect, done pulse 1 cycle after start, checksum=0, aborted=0.
REQ-041 Copy length=8, abort asserted in the 3rd RD -> exactly 3 words written, done with aborted=1.
REQ-042 start asserted while busy -> ignored, latched parameters unchanged, single done.
REQ-043 reset_n=0 during fill length=100 -> next cycle chipselect=0, busy=0, no done; a fresh start then runs normally.

Source files
------------

// File: rtl/mem_block_mover_if.sv
// Memory slave bus used by mem_block_mover: word-addressed, fixed one-cycle read latency,
// no wait states.
interface mem_block_mover_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                clken;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / fill engine: moves or fills a run of words on a single-port memory bus,
// reporting completion, abort status and a running sum of the written data.
module mem_block_mover #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum,
  mem_block_mover_if.master mem
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t            state;
  logic              mode_q;
  logic              abort_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   rem_q;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cs_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata;

  // Read data returns during the WR cycle itself, so copy data is forwarded straight
  // from readdata; wdata_q only holds the bus value between writes.
  always_comb begin
    wdata = wdata_q;
    if (state == WR) wdata = mode_q ? fill_q : mem.readdata;
  end

  assign mem.address    = addr_q;
  assign mem.chipselect = cs_q;
  assign mem.write      = wr_q;
  assign mem.writedata  = wdata;
  assign mem.byteenable = '1;
  assign mem.clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      checksum <= '0;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      abort_q  <= 1'b0;
      mode_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      fill_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            src_q    <= src_addr;
            dst_q    <= dst_addr;
            rem_q    <= length;
            fill_q   <= fill_value;
            checksum <= '0;
            aborted  <= 1'b0;
            abort_q  <= 1'b0;
            if (length == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (mode) begin
              state  <= WR;
              busy   <= 1'b1;
              cs_q   <= 1'b1;
              wr_q   <= 1'b1;
              addr_q <= dst_addr;
            end else begin
              state  <= RD;
              busy   <= 1'b1;
              cs_q   <= 1'b1;
              wr_q   <= 1'b0;
              addr_q <= src_addr;
            end
          end
        end
        RD: begin
          // An abort seen here is deferred until the paired write has gone out.
          state  <= WR;
          wr_q   <= 1'b1;
          addr_q <= dst_q;
          if (abort) abort_q <= 1'b1;
        end
        WR: begin
          checksum <= checksum + wdata;
          wdata_q  <= wdata;
          rem_q    <= rem_q - (ADDR_W+1)'(1);
          src_q    <= src_q + ADDR_W'(1);
          dst_q    <= dst_q + ADDR_W'(1);
          if (rem_q == (ADDR_W+1)'(1) || abort || abort_q) begin
            state   <= FIN;
            done    <= 1'b1;
            busy    <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            aborted <= (rem_q != (ADDR_W+1)'(1));
          end else if (mode_q) begin
            addr_q <= dst_q + ADDR_W'(1);
          end else begin
            state  <= RD;
            wr_q   <= 1'b0;
            addr_q <= src_q + ADDR_W'(1);
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed self-checking bench for mem_block_mover with a one-cycle-latency memory model.
module tb_mem_block_mover;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [12:0] src;
  logic [12:0] dst;
  logic [13:0] len;
  logic [31:0] fill;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  mem_block_mover_if #(.ADDR_W(13), .DATA_W(32)) m ();

  mem_block_mover #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src),
    .dst_addr   (dst),
    .length     (len),
    .fill_value (fill),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .checksum   (checksum),
    .mem        (m.master)
  );

  always #5 clk = ~clk;

  // Memory model plus activity logging
  logic [31:0] mem [0:8191];
  logic        pl_en = 1'b0;
  logic [12:0] pl_addr;
  logic [31:0] pl_data;
  int          wr_cnt = 0;
  int          cs_cnt = 0;
  int          done_cnt = 0;
  logic [12:0] wr_addr [$];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (m.chipselect && !m.write) m.readdata <= mem[m.address];
    if (m.chipselect && m.write) begin
      mem[m.address] <= m.writedata;
      wr_addr.push_back(m.address);
      wr_cnt <= wr_cnt + 1;
    end
    if (m.chipselect) cs_cnt <= cs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [12:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  logic busy_c1;

  // Issue one command; returns the cycle (counted from the accepting edge) in which done is seen.
  task automatic run(input logic md, input logic [12:0] s, input logic [12:0] d,
                     input logic [13:0] n, input logic [31:0] f,
                     input int abort_at, input int restart_at, output int cyc);
    @(negedge clk);
    mode = md; src = s; dst = d; len = n; fill = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_c1 = busy;
    while (!done && cyc < 400) begin
      abort = (cyc == abort_at);
      start = (cyc == restart_at);
      if (cyc == restart_at) begin
        mode = 1'b0; src = 13'h0AA; dst = 13'h400; len = 14'd1; fill = 32'h22;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    start = 1'b0;
    if (!done) chk("timeout", {31'd0, done}, 32'd1);
  endtask

  int cyc;
  int d0;
  int w0;
  int c0;

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0;
    len = '0; fill = '0; abort = 1'b0; m.readdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_aborted", {31'd0, aborted}, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_cs", {31'd0, m.chipselect}, 32'd0);
    chk("rst_write", {31'd0, m.write}, 32'd0);
    chk("rst_address", {19'd0, m.address}, 32'd0);
    chk("rst_writedata", m.writedata, 32'd0);
    chk("rst_clken", {31'd0, m.clken}, 32'd1);
    chk("byteenable", {28'd0, m.byteenable}, 32'hF);
    reset_n = 1'b1;

    for (int unsigned i = 0; i < 4; i++) poke(13'h010 + 13'(i), 32'(i + 1));
    poke(13'h020, 32'h100); poke(13'h021, 32'h200); poke(13'h022, 32'h300);
    poke(13'h023, 32'h400); poke(13'h024, 32'h500);
    poke(13'h600, 32'h0000_0007); poke(13'h601, 32'hFFFF_FFFF);

    // Copy 4 words
    d0 = done_cnt; w0 = wr_cnt;
    run(1'b0, 13'h010, 13'h100, 14'd4, 32'h0, 0, 0, cyc);
    chk("copy_busy", {31'd0, busy_c1}, 32'd1);
    chk("copy_latency", 32'(cyc), 32'd9);
    chk("copy_busy_at_done", {31'd0, busy}, 32'd0);
    chk("copy_checksum", checksum, 32'd10);
    chk("copy_aborted", {31'd0, aborted}, 32'd0);
    @(negedge clk);
    chk("copy_done_pulse", {31'd0, done}, 32'd0);
    chk("copy_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("copy_writes", 32'(wr_cnt - w0), 32'd4);
    for (int unsigned i = 0; i < 4; i++) chk("copy_mem", mem[13'h100 + 13'(i)], 32'(i + 1));

    // Fill across the address wrap
    wr_addr.delete();
    run(1'b1, 13'h0, 13'h1FFE, 14'd4, 32'hA5A5_A5A5, 0, 0, cyc);
    chk("fill_latency", 32'(cyc), 32'd5);
    chk("fill_checksum", checksum, 32'h9696_9694);
    @(negedge clk);
    chk("fill_nwr", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4) begin
      chk("fill_a0", {19'd0, wr_addr[0]}, 32'h1FFE);
      chk("fill_a1", {19'd0, wr_addr[1]}, 32'h1FFF);
      chk("fill_a2", {19'd0, wr_addr[2]}, 32'h0000);
      chk("fill_a3", {19'd0, wr_addr[3]}, 32'h0001);
    end
    chk("fill_mem0", mem[0], 32'hA5A5_A5A5);

    // Zero length
    c0 = cs_cnt; d0 = done_cnt;
    run(1'b0, 13'h010, 13'h100, 14'd0, 32'h0, 0, 0, cyc);
    chk("zero_latency", 32'(cyc), 32'd1);
    chk("zero_checksum", checksum, 32'd0);
    chk("zero_aborted", {31'd0, aborted}, 32'd0);
    @(negedge clk);
    chk("zero_cs", 32'(cs_cnt - c0), 32'd0);
    chk("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Abort during the third read of an 8-word copy
    w0 = wr_cnt;
    run(1'b0, 13'h020, 13'h200, 14'd8, 32'h0, 5, 0, cyc);
    chk("abort_latency", 32'(cyc), 32'd7);
    chk("abort_flag", {31'd0, aborted}, 32'd1);
    chk("abort_checksum", checksum, 32'h600);
    @(negedge clk);
    chk("abort_writes", 32'(wr_cnt - w0), 32'd3);
    chk("abort_mem2", mem[13'h202], 32'h300);
    chk("abort_flag_held", {31'd0, aborted}, 32'd1);

    // Start while busy is ignored
    wr_addr.delete(); d0 = done_cnt;
    run(1'b1, 13'h0, 13'h300, 14'd4, 32'h11, 0, 2, cyc);
    chk("busy_latency", 32'(cyc), 32'd5);
    chk("busy_checksum", checksum, 32'h44);
    chk("busy_aborted_clr", {31'd0, aborted}, 32'd0);
    repeat (3) @(negedge clk);
    chk("busy_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("busy_nwr", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4) chk("busy_last_addr", {19'd0, wr_addr[3]}, 32'h303);

    // Reset in the middle of a long fill
    @(negedge clk);
    mode = 1'b1; dst = 13'h500; len = 14'd100; fill = 32'h5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    reset_n = 1'b0;
    @(negedge clk);
    w0 = wr_cnt;
    chk("rstmid_cs", {31'd0, m.chipselect}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid_no_writes", 32'(wr_cnt - w0), 32'd0);
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);

    // Fresh copy after reset, with an operand that wraps the checksum
    run(1'b0, 13'h600, 13'h700, 14'd2, 32'h0, 0, 0, cyc);
    chk("post_latency", 32'(cyc), 32'd5);
    chk("post_checksum", checksum, 32'h6);
    @(negedge clk);
    chk("post_mem1", mem[13'h701], 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
